// File: rtl/mips_pkg.sv
// mips_pkg: shared register-index and write-back request types for the MIPS core.
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  typedef logic [ADDR_W-1:0] reg_idx_t;
  localparam reg_idx_t REG_ZERO = 5'd0;
  typedef struct packed {
    reg_idx_t          rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small synchronous FIFO of write-back requests with a per-entry valid/rd view.
module wb_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_req_t          din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output wb_req_t          head,
  output logic [DEPTH-1:0] ent_valid,
  output reg_idx_t         ent_rd [DEPTH]
);
  localparam int PW = $clog2(DEPTH);
  wb_req_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic do_push, do_pop;
  assign full    = count == (PW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  always_comb
    for (int i = 0; i < DEPTH; i++) ent_rd[i] = mem[i].rd;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (do_push) begin
        wr_ptr            <= wr_ptr + PW'(1);
        ent_valid[wr_ptr] <= 1'b1;
      end
      if (do_pop) begin
        rd_ptr            <= rd_ptr + PW'(1);
        ent_valid[rd_ptr] <= 1'b0;
      end
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges ALU and long-latency results onto the single register-file write port.
module regfile_wb_arbiter
  import mips_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  input  logic [ADDR_W-1:0]    alu_reg,
  input  logic [DATA_W-1:0]    alu_data,
  input  logic                 lng_valid,
  output logic                 lng_ready,
  input  logic [ADDR_W-1:0]    lng_reg,
  input  logic [DATA_W-1:0]    lng_data,
  output logic                 regWrite,
  output logic [ADDR_W-1:0]    W_reg,
  output logic [DATA_W-1:0]    W_data,
  output logic [2**ADDR_W-1:0] pending_mask,
  output logic                 stall_req
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  wb_req_t din, head;
  logic full, empty, push, pop, win;
  logic [DEPTH-1:0] ent_valid;
  reg_idx_t ent_rd [DEPTH];
  logic [ADDR_W-1:0] win_reg;
  logic [DATA_W-1:0] win_data;
  logic [CW-1:0] starve, starve_next;
  assign din       = '{rd: lng_reg, data: lng_data};
  assign push      = lng_valid && !full;
  assign pop       = !alu_valid && !empty;
  assign lng_ready = !full;
  assign win       = alu_valid || pop;
  assign win_reg   = alu_valid ? alu_reg : ADDR_W'(head.rd);
  assign win_data  = alu_valid ? alu_data : DATA_W'(head.data);
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk, .rst, .push, .din, .pop, .full, .empty, .head, .ent_valid, .ent_rd
  );
  // Starvation only accrues while a long result waits behind a live ALU stream.
  always_comb
    starve_next = pop ? '0 :
                  (!empty && alu_valid && starve < CW'(STARVE_LIMIT)) ? starve + CW'(1) : starve;
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_valid[i] && ent_rd[i] != REG_ZERO) pending_mask[ent_rd[i]] = 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      regWrite  <= 1'b0;
      W_reg     <= '0;
      W_data    <= '0;
      starve    <= '0;
      stall_req <= 1'b0;
    end else begin
      regWrite  <= win && win_reg != '0;
      starve    <= starve_next;
      stall_req <= starve_next >= CW'(STARVE_LIMIT);
      if (win) begin
        W_reg  <= win_reg;
        W_data <= win_data;
      end
    end
endmodule
